// File: rtl/tlast_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite register programming sequencer.
package tlast_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StFinish
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_RESP      = 2'b01;
  localparam logic [1:0] ERR_MISMATCH  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/tlast_cfg_watchdog.sv
// 8-bit handshake watchdog: counts enabled cycles since the last clear and flags the limit.
module tlast_cfg_watchdog (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] limit_i,
  output logic       expired_o
);

  logic [7:0] cnt_q;

  // The count starts at 0 on the first cycle of a wait, so limit-1 marks the limit-th cycle.
  assign expired_o = (cnt_q == (limit_i - 8'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/tlast_cfg_sequencer.sv
// Programs NUM_REGS AXI4-Lite registers from cfg_data, optionally reading each back.
// Read-back phase is built only when TLAST_CFG_READBACK_EN is defined.
module tlast_cfg_sequencer
  import tlast_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [NUM_REGS*32-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            err_idx,
  output logic [1:0]            err_code,
  output logic [31:0]           m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [3:0] LastIdx = 4'(NUM_REGS - 1);
  localparam logic [7:0] WdLimit = 8'(TIMEOUT_CYCLES);

  state_e                 state_q;
  logic [NUM_REGS*32-1:0] cfg_q;
  logic [3:0]             idx_q, nxt_idx;
  logic                   busy_q, done_q, error_q;
  logic [3:0]             err_idx_q;
  logic [1:0]             err_code_q;
  logic                   awvalid_q, wvalid_q, bready_q;
  logic [31:0]            awaddr_q, wdata_q, nxt_word;
  logic                   aw_done, w_done;
  logic                   wd_en, wd_step, wd_clr, wd_expired;
  logic                   fail;
  logic [1:0]             fail_code;

  assign nxt_idx  = idx_q + 4'd1;
  assign nxt_word = 32'(cfg_q >> {nxt_idx, 5'd0});
  // A channel counts as done once its VALID has already dropped or is being accepted now.
  assign aw_done  = !awvalid_q || m_axi_awready;
  assign w_done   = !wvalid_q || m_axi_wready;
  assign wd_clr   = !wd_en || wd_step;

`ifdef TLAST_CFG_READBACK_EN
  logic        arvalid_q, rready_q;
  logic [31:0] araddr_q, cur_word;
  assign cur_word = 32'(cfg_q >> {idx_q, 5'd0});
`else
  logic unused_rd;
  assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

  tlast_cfg_watchdog u_watchdog (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .limit_i   (WdLimit),
    .expired_o (wd_expired)
  );

  always_comb begin
    wd_en     = 1'b0;
    wd_step   = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    case (state_q)
      StWrReq: begin
        wd_en   = 1'b1;
        wd_step = aw_done && w_done;
      end
      StWrResp: begin
        wd_en   = 1'b1;
        wd_step = m_axi_bvalid;
        if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
          fail      = 1'b1;
          fail_code = ERR_RESP;
        end
      end
`ifdef TLAST_CFG_READBACK_EN
      StRdReq: begin
        wd_en   = 1'b1;
        wd_step = m_axi_arready;
      end
      StRdResp: begin
        wd_en   = 1'b1;
        wd_step = m_axi_rvalid;
        if (m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY)) begin
          fail      = 1'b1;
          fail_code = ERR_RESP;
        end else if (m_axi_rvalid && (m_axi_rdata != cur_word)) begin
          fail      = 1'b1;
          fail_code = ERR_MISMATCH;
        end
      end
`endif
      default: ;
    endcase
    // A handshake landing on the expiry cycle wins over the timeout.
    if (wd_en && !wd_step && wd_expired) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      cfg_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= ERR_NONE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef TLAST_CFG_READBACK_EN
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (fail) begin
        error_q    <= 1'b1;
        err_idx_q  <= idx_q;
        err_code_q <= fail_code;
        awvalid_q  <= 1'b0;
        wvalid_q   <= 1'b0;
        bready_q   <= 1'b0;
`ifdef TLAST_CFG_READBACK_EN
        arvalid_q  <= 1'b0;
        rready_q   <= 1'b0;
`endif
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        state_q    <= StFinish;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              cfg_q      <= cfg_data;
              idx_q      <= '0;
              error_q    <= 1'b0;
              err_idx_q  <= '0;
              err_code_q <= ERR_NONE;
              busy_q     <= 1'b1;
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
              awaddr_q   <= reg_addr(BASE_ADDR, 4'd0);
              wdata_q    <= cfg_data[31:0];
              state_q    <= StWrReq;
            end
          end
          StWrReq: begin
            if (m_axi_awready) awvalid_q <= 1'b0;
            if (m_axi_wready) wvalid_q <= 1'b0;
            if (aw_done && w_done) begin
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end
          end
          StWrResp: begin
            if (m_axi_bvalid) begin
              bready_q <= 1'b0;
              if (idx_q == LastIdx) begin
`ifdef TLAST_CFG_READBACK_EN
                idx_q     <= '0;
                arvalid_q <= 1'b1;
                araddr_q  <= reg_addr(BASE_ADDR, 4'd0);
                state_q   <= StRdReq;
`else
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= StFinish;
`endif
              end else begin
                idx_q     <= nxt_idx;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                awaddr_q  <= reg_addr(BASE_ADDR, nxt_idx);
                wdata_q   <= nxt_word;
                state_q   <= StWrReq;
              end
            end
          end
`ifdef TLAST_CFG_READBACK_EN
          StRdReq: begin
            if (m_axi_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= StRdResp;
            end
          end
          StRdResp: begin
            if (m_axi_rvalid) begin
              rready_q <= 1'b0;
              if (idx_q == LastIdx) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StFinish;
              end else begin
                idx_q     <= nxt_idx;
                arvalid_q <= 1'b1;
                araddr_q  <= reg_addr(BASE_ADDR, nxt_idx);
                state_q   <= StRdReq;
              end
            end
          end
`endif
          StFinish: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_idx       = err_idx_q;
  assign err_code      = err_code_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arprot  = 3'b000;
`ifdef TLAST_CFG_READBACK_EN
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
`else
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_tlast_cfg_sequencer.sv
// Self-checking bench for tlast_cfg_sequencer with a configurable AXI4-Lite slave model.
module tb_tlast_cfg_sequencer;
  import tlast_cfg_pkg::*;

`ifdef TLAST_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int NR     = 4;
  localparam int TO     = 255;
  localparam int BUDGET = 400;
  localparam int PASS_LAT = RB ? 4 * NR + 2 : 2 * NR + 2;

  logic            ACLK = 1'b0;
  logic            ARESET, start;
  logic [NR*32-1:0] cfg_data;
  logic            busy, done, error;
  logic [3:0]      err_idx;
  logic [1:0]      err_code;
  logic [31:0]     awaddr, wdata, araddr, rdata;
  logic [2:0]      awprot, arprot;
  logic [3:0]      wstrb;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [1:0]      bresp, rresp;

  always #5 ACLK = ~ACLK;

  tlast_cfg_sequencer #(
    .NUM_REGS       (NR),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (start),
    .cfg_data      (cfg_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_idx       (err_idx),
    .err_code      (err_code),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  // Slave model knobs; -1 disables an injected fault.
  int aw_lat = 0, w_lat = 0, berr_idx = -1, corrupt_idx = -1, hang_idx = -1;
  int aw_wait = 0, w_wait = 0;
  logic aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [31:0] mem [16];

  assign awready = (aw_wait >= aw_lat);
  assign wready  = (w_wait >= w_lat);
  assign arready = 1'b1;

  always @(posedge ACLK) begin
    logic ga, gw;
    logic [31:0] a, d;
    int k;
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      ga = aw_got; a = aw_a;
      if (awvalid && awready) begin ga = 1'b1; a = awaddr; end
      gw = w_got; d = w_d;
      if (wvalid && wready) begin gw = 1'b1; d = wdata; end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ga && gw) begin
        k = int'(a[5:2]);
        mem[k] <= d;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (k != hang_idx) begin
          bvalid <= 1'b1;
          bresp  <= (k == berr_idx) ? 2'b10 : 2'b00;
        end
      end else begin
        aw_got <= ga; w_got <= gw; aw_a <= a; w_d <= d;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        k = int'(araddr[5:2]);
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        rdata  <= (k == corrupt_idx) ? 32'hDEADBEEF : mem[k];
      end
    end
  end

  // Bus monitor: transfer logs, VALID/payload stability, ordering.
  logic [31:0] aw_log[$], w_log[$];
  int b_cnt, ar_cnt, split_cnt, stab_err, ar_early;
  logic aw_p, w_p, ar_p;
  logic [31:0] aw_pa, w_pd, ar_pa;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_p <= 1'b0; w_p <= 1'b0; ar_p <= 1'b0;
    end else begin
      if (aw_p && !(awvalid && awaddr == aw_pa)) stab_err++;
      if (w_p && !(wvalid && wdata == w_pd)) stab_err++;
      if (ar_p && !(arvalid && araddr == ar_pa)) stab_err++;
      aw_p <= awvalid && !awready; aw_pa <= awaddr;
      w_p  <= wvalid && !wready;   w_pd  <= wdata;
      ar_p <= arvalid && !arready; ar_pa <= araddr;
      if (awvalid && awready) aw_log.push_back(awaddr);
      if (wvalid && wready) w_log.push_back(wdata);
      if (bvalid && bready) b_cnt++;
      if (arvalid && arready) ar_cnt++;
      if (arvalid && b_cnt < NR) ar_early++;
      if (!awvalid && wvalid) split_cnt++;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    aw_log.delete(); w_log.delete();
    b_cnt = 0; ar_cnt = 0; split_cnt = 0; stab_err = 0; ar_early = 0;
  endtask

  // Called at a negedge; returns inclusive start-to-done cycle count.
  task automatic wait_done(input int n0, output int lat);
    int n = n0;
    while (!done && n < BUDGET) begin
      @(negedge ACLK);
      n++;
    end
    lat = n + 1;
    if (!done) begin
      failures++;
      $display("FAIL done_wait actual=no_done required=done_within_%0d", BUDGET);
    end
  endtask

  task automatic run_seq(input logic [NR*32-1:0] d, output int lat);
    cfg_data = d;
    start    = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    wait_done(1, lat);
  endtask

  typedef struct {
    logic [NR*32-1:0] data;
    int aw_lat, w_lat, berr, corrupt, hang;
    int lat;
    bit err;
    logic [3:0] idx;
    logic [1:0] code;
    int nb, nwr;
    bit split;
  } vec_t;

  localparam logic [NR*32-1:0] D1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [NR*32-1:0] D2 = 128'h5A5A5A5A_A5A5A5A5_00000000_FFFFFFFF;
  localparam logic [NR*32-1:0] D3 = 128'h13579BDF_2468ACE0_0BADF00D_CAFEF00D;

  vec_t v[7];

  initial begin
    int lat, exp_ar;
    string s;
    v[0] = '{D1, 0, 0, -1, -1, -1, PASS_LAT, 1'b0, 4'd0, ERR_NONE, NR, NR, 1'b0};
    v[1] = '{D2, 0, 0, -1, -1, -1, PASS_LAT, 1'b0, 4'd0, ERR_NONE, NR, NR, 1'b0};
    v[2] = '{D3, 1, 4, -1, -1, -1, RB ? 34 : 26, 1'b0, 4'd0, ERR_NONE, NR, NR, 1'b1};
    v[3] = '{D1, 0, 0, 2, -1, -1, 8, 1'b1, 4'd2, ERR_RESP, 3, 3, 1'b0};
    v[4] = '{D1, 0, 0, -1, 3, -1, PASS_LAT, RB, RB ? 4'd3 : 4'd0,
             RB ? ERR_MISMATCH : ERR_NONE, NR, NR, 1'b0};
    v[5] = '{D2, 0, 0, -1, -1, 0, 2 + TO + 1, 1'b1, 4'd0, ERR_TIMEOUT, 0, 1, 1'b0};
    v[6] = '{D3, 0, 0, -1, -1, -1, PASS_LAT, 1'b0, 4'd0, ERR_NONE, NR, NR, 1'b0};

    ARESET = 1'b1; start = 1'b0; cfg_data = '0;
    clear_mon();
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
    check("rst_err", {err_idx, err_code}, 6'h00);
    check("rst_addr", {awaddr, wdata, araddr}, '0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      aw_lat = v[i].aw_lat; w_lat = v[i].w_lat;
      berr_idx = v[i].berr; corrupt_idx = v[i].corrupt; hang_idx = v[i].hang;
      clear_mon();
      run_seq(v[i].data, lat);
      s = $sformatf("v%0d", i);
      check({s, "_lat"}, lat, v[i].lat);
      check({s, "_busy_at_done"}, busy, 1'b0);
      check({s, "_error"}, error, v[i].err);
      check({s, "_err_idx"}, err_idx, v[i].idx);
      check({s, "_err_code"}, err_code, v[i].code);
      check({s, "_b_count"}, b_cnt, v[i].nb);
      check({s, "_aw_count"}, aw_log.size(), v[i].nwr);
      check({s, "_w_count"}, w_log.size(), v[i].nwr);
      for (int k = 0; k < v[i].nwr && k < aw_log.size() && k < w_log.size(); k++) begin
        check($sformatf("%s_awaddr%0d", s, k), aw_log[k], 32'(k * 4));
        check($sformatf("%s_wdata%0d", s, k), w_log[k], v[i].data[k*32 +: 32]);
      end
      exp_ar = (RB && v[i].nb == NR) ? NR : 0;
      check({s, "_ar_count"}, ar_cnt, exp_ar);
      check({s, "_ar_before_b"}, ar_early, 0);
      check({s, "_stability"}, stab_err, 0);
      check({s, "_aw_w_split"}, split_cnt != 0, v[i].split);
      @(negedge ACLK);
      check({s, "_done_pulse"}, done, 1'b0);
      check({s, "_error_sticky"}, error, v[i].err);
      @(negedge ACLK);
    end
    aw_lat = 0; w_lat = 0; berr_idx = -1; corrupt_idx = -1; hang_idx = -1;

    // Start while busy is ignored.
    clear_mon();
    cfg_data = D1; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    cfg_data = D2; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    wait_done(3, lat);
    check("busy_start_lat", lat, PASS_LAT);
    check("busy_start_wcount", w_log.size(), NR);
    check("busy_start_word3", w_log[3], 32'h4);
    check("busy_start_error", error, 1'b0);

    // Start on the done cycle is ignored; start on the next cycle is accepted.
    cfg_data = D2; start = 1'b1;
    @(negedge ACLK);
    check("start_at_done_ignored", busy, 1'b0);
    clear_mon();
    @(negedge ACLK);
    start = 1'b0;
    check("start_after_done_accepted", busy, 1'b1);
    wait_done(1, lat);
    check("restart_lat", lat, PASS_LAT);
    check("restart_word0", w_log[0], 32'hFFFFFFFF);
    check("restart_error", error, 1'b0);
    @(negedge ACLK);

    // Reset in the middle of a sequence, then a clean rerun.
    clear_mon();
    cfg_data = D1; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    repeat ((RB ? 10 : 4) - 1) @(negedge ACLK);
    check("pre_reset_resp_phase", RB ? rready : bready, 1'b1);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_reset_idle", {busy, done, error, awvalid, wvalid, bready, arvalid, rready},
          8'h00);
    clear_mon();
    run_seq(D3, lat);
    check("post_reset_lat", lat, PASS_LAT);
    check("post_reset_error", error, 1'b0);
    check("post_reset_b_count", b_cnt, NR);
    check("post_reset_word2", w_log[2], 32'h2468ACE0);
    check("post_reset_stability", stab_err, 0);
    @(negedge ACLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/tlast_cfg_sequencer.md
TLAST_CFG_SEQUENCER -- requirements
Module: tlast_cfg_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 4: number of 32-bit slave registers to program, range 1..16.
REQ-002 Parameter BASE_ADDR, default 0: byte address of register 0; register k is at BASE_ADDR+4k.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for any single AXI handshake.
REQ-004 ACLK  in  1  sole clock; all logic is rising-edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a programming sequence; ignored while busy=1.
REQ-007 cfg_data  in  NUM_REGS*32  register values, word k in bits [32k+31:32k]; captured on accepted start.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse at sequence end, whether pass or fail.
REQ-010 error  out  1  sticky fail flag; cleared on the next accepted start.
REQ-011 err_idx  out  4  register index of the first failure.
REQ-012 err_code  out  2  first failure cause: 00 none, 01 BRESP/RRESP not OKAY, 10 read-back mismatch, 11 timeout.
REQ-013 AW channel: m_axi_awaddr out 32, m_axi_awprot out 3 (tied 0), m_axi_awvalid out 1, m_axi_awready in 1.
REQ-014 W channel: m_axi_wdata out 32, m_axi_wstrb out 4 (tied 4'hF), m_axi_wvalid out 1, m_axi_wready in 1.
REQ-015 B channel: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-016 AR channel: m_axi_araddr out 32, m_axi_arprot out 3 (tied 0), m_axi_arvalid out 1, m_axi_arready in 1.
REQ-017 R channel: m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.

Function
REQ-018 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
REQ-019 IDLE + start: capture cfg_data, clear index, error, err_idx, err_code; go to WR_REQ.
REQ-020 WR_REQ: assert awvalid and wvalid together; each drops independently on its own handshake; both done -> WR_RESP.
REQ-021 WR_RESP: bready=1; on bvalid go to WR_REQ for next index, or to RD_REQ at index NUM_REGS-1 with index reset to 0.
REQ-022 RD_REQ: arvalid until arready -> RD_RESP; RD_RESP: rready=1, on rvalid compare rdata against captured word.
REQ-023 RD_RESP advances to RD_REQ for the next index, or to FINISH after index NUM_REGS-1.
REQ-024 VALID signals, once asserted, hold with stable address/data until handshake.
REQ-025 Only one transaction outstanding; no AR issued before the last B is received.
REQ-026 Each wait state runs an 8-bit watchdog cleared on entry; reaching TIMEOUT_CYCLES -> code 11, go to FINISH, drop all VALID/READY.
REQ-027 BRESP/RRESP != OKAY -> code 01; mismatch -> code 10; first failure aborts to FINISH; later causes not recorded.
REQ-028 FINISH: done=1 for exactly one cycle, busy=0 on the same cycle, next state IDLE.
REQ-029 start coincident with done is ignored; start the following cycle is accepted.
REQ-030 Minimum sequence length with zero-wait slave: 4*NUM_REGS+2 cycles from start to done.

Reset
REQ-031 ARESET=1 forces IDLE; busy, done, error, all VALID/READY outputs 0; err_idx 0, err_code 00; addresses/wdata 0.
REQ-032 ARESET mid-transaction abandons it without completing handshakes; first cycle after release is IDLE.

Configuration
REQ-033 Macro TLAST_CFG_READBACK_EN defined: RD_REQ/RD_RESP phases run as in REQ-022/023.
REQ-034 Macro undefined: after last B, go directly to FINISH; AR/R outputs held 0; code 10 never produced; minimum latency 2*NUM_REGS+2.

Structure
REQ-035 Package tlast_cfg_pkg holds the state enum, err_code constants (ERR_NONE, ERR_RESP, ERR_MISMATCH, ERR_TIMEOUT), AXI OKAY constant.
REQ-036 Sub-module tlast_cfg_watchdog: 8-bit counter with clear, enable, limit input, expired output.

Verification
REQ-037 Zero-wait slave, cfg_data words 1,2,3,4 -> writes to 0x0,0x4,0x8,0xC in order, read-back matches, done at cycle 18, error=0.
REQ-038 Slave with awready 3 cycles before wready -> awvalid drops first, wvalid held, single B per word, pass.
REQ-039 Slave returns BRESP=2'b10 on index 2 -> no AR issued, done, error=1, err_idx=2, err_code=01.
REQ-040 Slave corrupts register 3 to 0xDEADBEEF -> err_idx=3, err_code=10.
REQ-041 bvalid never asserted on index 0 -> done at TIMEOUT_CYCLES after WR_RESP entry, err_code=11.
REQ-042 ARESET pulsed during RD_RESP, then start -> clean IDLE, full sequence repeats and passes.
